// File: rtl/duty_step_counter.sv
`default_nettype none
// ============================================================================
// Module   : duty_step_counter
// Purpose  : Push-button up/down setpoint counter driving the DPWM duty word,
//            with input sync, wrap/saturate limits and press-and-hold repeat.
// Revision : 1.0  initial release
// ============================================================================
module duty_step_counter #(
    parameter int WIDTH       = 3,
    parameter int MIN_VAL     = 0,
    parameter int MAX_VAL     = 2**WIDTH - 1,
    parameter int RESET_VAL   = 0,
    parameter int STEP        = 1,
    parameter int WRAP        = 1,
    parameter int REPEAT_DLY  = 0,
    parameter int REPEAT_RATE = 1
) (
    input  logic             clkm,
    input  logic             reset,
    input  logic             aumentar,
    input  logic             disminuir,
    output logic [WIDTH-1:0] outcont,
    output logic             at_max,
    output logic             at_min,
    output logic             changed
);

    localparam int c_TMAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
    localparam int c_TW   = $clog2(c_TMAX + 1);

    localparam logic [WIDTH:0]   c_MAX_X   = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH:0]   c_STEP_X  = (WIDTH+1)'(STEP);
    localparam logic [WIDTH:0]   c_DN_LIM  = (WIDTH+1)'(MIN_VAL + STEP);
    localparam logic [WIDTH-1:0] c_MAX     = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] c_MIN     = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] c_STEP    = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] c_RST     = WIDTH'(RESET_VAL);
    localparam logic [c_TW-1:0]  c_DLY_LD  = (REPEAT_DLY > 0) ? c_TW'(REPEAT_DLY - 1) : '0;
    localparam logic [c_TW-1:0]  c_RATE_LD = c_TW'(REPEAT_RATE - 1);
    localparam bit               c_WRAP    = (WRAP != 0);
    localparam bit               c_AUTO    = (REPEAT_DLY != 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DELAY  = 2'd1,
        S_REPEAT = 2'd2
    } state_t;

    state_t            r_state, w_state_nx;
    logic [c_TW-1:0]   r_tmr, w_tmr_nx;
    logic              r_ldir, w_ldir_nx;
    logic [WIDTH-1:0]  r_cnt;
    logic              r_chg;
    logic              r_s1_aum, r_s2_aum, r_s1_dis, r_s2_dis;

    logic              w_up, w_act, w_step;
    logic [WIDTH:0]    w_sum;
    logic [WIDTH-1:0]  w_nxt;

    always_ff @(posedge clkm or posedge reset) begin
        if (reset) begin
            r_s1_aum <= 1'b0;
            r_s2_aum <= 1'b0;
            r_s1_dis <= 1'b0;
            r_s2_dis <= 1'b0;
        end else begin
            r_s1_aum <= aumentar;
            r_s2_aum <= r_s1_aum;
            r_s1_dis <= disminuir;
            r_s2_dis <= r_s1_dis;
        end
    end

    // Both buttons held is treated as no request at all.
    assign w_up  = r_s2_aum & ~r_s2_dis;
    assign w_act = r_s2_aum ^ r_s2_dis;

    always_ff @(posedge clkm or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_tmr   <= '0;
            r_ldir  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_tmr   <= w_tmr_nx;
            r_ldir  <= w_ldir_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_tmr_nx   = r_tmr;
        w_ldir_nx  = r_ldir;
        w_step     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_act) begin
                    w_step     = 1'b1;
                    w_ldir_nx  = w_up;
                    w_tmr_nx   = c_DLY_LD;
                    w_state_nx = S_DELAY;
                end
            end
            S_DELAY, S_REPEAT: begin
                if (!w_act) begin
                    w_state_nx = S_IDLE;
                    w_tmr_nx   = '0;
                end else if (w_up != r_ldir) begin
                    // A direction reversal behaves like a fresh press.
                    w_step     = 1'b1;
                    w_ldir_nx  = w_up;
                    w_tmr_nx   = c_DLY_LD;
                    w_state_nx = S_DELAY;
                end else if (!c_AUTO) begin
                    w_tmr_nx   = r_tmr;
                end else if (r_tmr == '0) begin
                    w_step     = 1'b1;
                    w_tmr_nx   = c_RATE_LD;
                    w_state_nx = S_REPEAT;
                end else begin
                    w_tmr_nx   = r_tmr - c_TW'(1);
                end
            end
            default: begin
                w_state_nx = S_IDLE;
                w_tmr_nx   = '0;
            end
        endcase
    end

    assign w_sum = {1'b0, r_cnt} + c_STEP_X;

    always_comb begin
        w_nxt = r_cnt;
        if (w_up) begin
            if (w_sum > c_MAX_X) begin
                w_nxt = c_WRAP ? c_MIN : c_MAX;
            end else begin
                w_nxt = w_sum[WIDTH-1:0];
            end
        end else begin
            if ({1'b0, r_cnt} < c_DN_LIM) begin
                w_nxt = c_WRAP ? c_MAX : c_MIN;
            end else begin
                w_nxt = r_cnt - c_STEP;
            end
        end
    end

    always_ff @(posedge clkm or posedge reset) begin
        if (reset) begin
            r_cnt <= c_RST;
            r_chg <= 1'b0;
        end else begin
            r_chg <= w_step && (w_nxt != r_cnt);
            if (w_step) begin
                r_cnt <= w_nxt;
            end
        end
    end

    assign outcont = r_cnt;
    assign changed = r_chg;
    assign at_max  = (r_cnt == c_MAX);
    assign at_min  = (r_cnt == c_MIN);

endmodule
`default_nettype wire
